hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage core. Generates the stall and flush controls for the IF/ID register, PC and ID/EX register. Detects load-use hazards, taken-branch redirects and instruction/data memory wait states. Also keeps saturating stall/flush statistics and a sticky memory-timeout flag.

---
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/hazard_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: hazard sources in, stall/flush controls
// and statistics out.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             IDEX_MemRead;
  logic [REG_W-1:0] IDEX_rd;
  logic [REG_W-1:0] IFID_rs1;
  logic [REG_W-1:0] IFID_rs2;
  logic             branch_taken;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;
  logic             PCstall;
  logic             IFstall;
  logic             IFflush;
  logic             IDEXflush;
  logic             pipe_stall;
  logic             busy_wait;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output IDEX_MemRead, IDEX_rd, IFID_rs1, IFID_rs2, branch_taken,
           imem_ready, dmem_req, dmem_ready,
    input  PCstall, IFstall, IFflush, IDEXflush, pipe_stall,
           busy_wait, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  IDEX_MemRead, IDEX_rd, IFID_rs1, IFID_rs2, branch_taken,
           imem_ready, dmem_req, dmem_ready,
    output PCstall, IFstall, IFflush, IDEXflush, pipe_stall,
           busy_wait, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use, branch redirect and
// memory wait handling, with saturating statistics and a sticky wait timeout.
module hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave bus
);
  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam int         WC_W   = $clog2(TIMEOUT + 1);

  logic [0:0]       r_state;
  logic [WC_W-1:0]  r_wait_cnt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [REG_W-1:0] w_rd;
  logic             w_mem_wait;
  logic             w_lu_hazard;
  logic             w_pcstall;
  logic             w_ifflush;
  logic             w_idexflush;
  logic             w_pipe_stall;

  assign w_rd        = bus.IDEX_rd;
  assign w_mem_wait  = !bus.imem_ready || (bus.dmem_req && !bus.dmem_ready);
  assign w_lu_hazard = bus.IDEX_MemRead && (w_rd != '0) &&
                       ((w_rd == bus.IFID_rs1) || (w_rd == bus.IFID_rs2));

  // Same priority in both states; MEM_WAIT only differs in busy_wait and the
  // wait counter, so the exit cycle resolves hazards/branches like RUN does.
  always_comb begin
    w_pcstall    = 1'b0;
    w_ifflush    = 1'b0;
    w_idexflush  = 1'b0;
    w_pipe_stall = 1'b0;
    if (!rst) begin
      if (w_mem_wait) begin
        w_pcstall    = 1'b1;
        w_pipe_stall = 1'b1;
      end else if (w_lu_hazard) begin
        w_pcstall    = 1'b1;
        w_idexflush  = 1'b1;
      end else if (bus.branch_taken) begin
        w_ifflush    = 1'b1;
      end
    end
  end

  assign bus.PCstall     = w_pcstall;
  assign bus.IFstall     = w_pcstall;
  assign bus.IFflush     = w_ifflush;
  assign bus.IDEXflush   = w_idexflush;
  assign bus.pipe_stall  = w_pipe_stall;
  assign bus.busy_wait   = !rst && (r_state == S_WAIT);
  assign bus.mem_timeout = r_timeout;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: if (w_mem_wait) begin
          r_state    <= S_WAIT;
          r_wait_cnt <= WC_W'(1);
        end
        default: if (w_mem_wait) begin
          // A wait already TIMEOUT cycles long that is still pending has exceeded it.
          if (r_wait_cnt == WC_W'(TIMEOUT)) r_timeout <= 1'b1;
          else                              r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
          r_state    <= S_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pcstall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_ifflush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
endmodule
